apb_master: RTL and testbench
=============================

# apb_master

APB requester that turns a simple valid/ready command interface into single APB3 transfers (SETUP then ACCESS), waits for PREADY, and returns read data and error status on a valid/ready response interface. It sits on the bus side opposite the timer's APB register slave. It drives the bus in testbenches and in on-chip controllers that program timer registers (TCR/TDR/TSR) without a CPU. A bounded wait counter aborts transfers whose completer never raises PREADY.

## Interface
- ADDR_W, 8, PADDR and cmd_addr width
- DATA_W, 8, PWDATA/PRDATA and command/response data width
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

- PCLK  in  1  sole clock, all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data, ignored for reads
- rsp_valid  out  1  response available, held until rsp_ready
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by the wait counter
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address and write data
- PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1  APB completer response

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch write/addr/wdata onto PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Always lasts exactly one cycle, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: capture PRDATA into rsp_rdata (reads only; writes give 0), rsp_err=PSLVERR, rsp_timeout=0, go to RESP.
  - PREADY=0: increment wait_cnt.
  - PREADY=0 with wait_cnt==TIMEOUT-1 and TIMEOUT≠0: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - PREADY has priority over timeout in the same cycle.
- RESP: PSEL=PENABLE=0, rsp_valid=1. On rsp_ready, go to IDLE. cmd_ready=0 throughout.
- wait_cnt clears on entry to ACCESS. Width is clog2(TIMEOUT+1), minimum 1.
- PADDR/PWRITE/PWDATA are held from SETUP through ACCESS and keep their last values afterwards. They change only on command acceptance.
- PSLVERR is only sampled when PREADY=1 in ACCESS. PRDATA is ignored on writes.
- Reset mid-transfer: the next edge with PRESETn=0 forces IDLE and drops PSEL/PENABLE. No response is issued for the aborted command.

## Timing
- Reset values: all outputs 0 except cmd_ready. cmd_ready=0 during reset and 1 from the first cycle after PRESETn returns high. FSM=IDLE, wait_cnt=0.
- Command accepted at edge N: SETUP during cycle N+1, ACCESS from N+2.
- Zero-wait completer (PREADY=1 in the first ACCESS cycle): rsp_valid high at N+3.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- Timeout: ACCESS lasts at most TIMEOUT cycles. PSEL drops and rsp_valid rises on the following cycle.
- Response accepted at edge M: cmd_ready=1 at M+1. The next command can be accepted at M+1, giving a minimum 4-cycle issue interval.
- All outputs are registered. There are no combinational paths from APB inputs to outputs.

## Structure
- Shared package apb_master_pkg holds:
  - the state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3);
  - APB_READ/APB_WRITE constants;
  - the default ADDR_W/DATA_W, shared with the timer register map.
- One natural sub-module, apb_wait_timer: a parameterised wait counter with clear, enable and expire outputs. It is reusable by other requesters. The FSM and datapath stay in apb_master.

## Test plan
- Write 0x5A to 0x00, completer PREADY=1 immediately: PSEL high at N+1..N+2, PENABLE only at N+2, PWDATA=0x5A. rsp_valid at N+3 with err=0, rdata=0x00.
- Read 0x04, PRDATA=0xC3, PREADY low 3 cycles then high: ACCESS lasts 4 cycles, rsp_rdata=0xC3, rsp_err=0.
- Write 0x08 with PSLVERR=1 at PREADY: rsp_err=1, rsp_timeout=0. The next command is accepted the cycle after rsp_ready.
- PREADY stuck low, TIMEOUT=16: exactly 16 ACCESS cycles, then PSEL=0 and rsp_err=rsp_timeout=1, rdata=0. With TIMEOUT=0 the bus stays in ACCESS for 100+ cycles.
- rsp_ready held low 5 cycles: rsp_valid/rdata stable, cmd_ready=0, and a new cmd_valid is not accepted until after the response handshake.
- PRESETn=0 for one cycle during ACCESS: PSEL/PENABLE=0 next cycle, no rsp_valid. A subsequent read completes normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared FSM encoding, APB direction constants and default bus widths
package apb_master_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_e;
  localparam logic APB_READ = 1'b0;
  localparam logic APB_WRITE = 1'b1;
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts enabled wait cycles and flags the last one allowed; TIMEOUT=0 never expires
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);
  always_comb cnt_d = clr_i ? '0 : (en_i && !expire_o) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= !rst_ni ? '0 : cnt_d;
endmodule

// File: rtl/apb_master.sv
// apb_master: valid/ready command to single APB3 transfer requester with bounded PREADY wait
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  state_e state_q, state_d;
  logic rdy_q, pwrite_q, err_q, to_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rdata_q;
  logic accept, done, expire;
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk_i(PCLK),
    .rst_ni(PRESETn),
    .clr_i(state_q == SETUP),
    .en_i(state_q == ACCESS && !PREADY),
    .expire_o(expire)
  );
  // rdy_q implies IDLE and stays low through reset, so no accept on the release edge
  always_comb accept = cmd_valid && rdy_q;
  always_comb done = (state_q == ACCESS) && (PREADY || expire);
  always_ff @(posedge PCLK) state_q <= !PRESETn ? IDLE : state_d;
  always_comb
    state_d = accept ? SETUP :
              (state_q == SETUP) ? ACCESS :
              done ? RESP :
              (state_q == RESP && rsp_ready) ? IDLE : state_q;
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      rdy_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      rdy_q <= state_d == IDLE;
      if (accept) begin
        pwrite_q <= cmd_write;
        paddr_q <= cmd_addr;
        pwdata_q <= cmd_wdata;
      end
      if (done) begin
        rdata_q <= (PREADY && pwrite_q == APB_READ) ? PRDATA : '0;
        err_q <= !PREADY || PSLVERR;
        to_q <= !PREADY;
      end
    end
  end
  always_comb begin
    cmd_ready = rdy_q;
    PSEL = state_q == SETUP || state_q == ACCESS;
    PENABLE = state_q == ACCESS;
    rsp_valid = state_q == RESP;
    PWRITE = pwrite_q;
    PADDR = paddr_q;
    PWDATA = pwdata_q;
    rsp_rdata = rdata_q;
    rsp_err = err_q;
    rsp_timeout = to_q;
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed vector table plus hand sequences for backpressure, timeout and reset abort
module tb_apb_master;
  logic PCLK = 1'b0, PRESETn = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0, PRDATA = '0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE;
  logic [7:0] rsp_rdata, PADDR, PWDATA;
  logic z_cmd_ready, z_rsp_valid, z_rsp_err, z_rsp_timeout, z_PSEL, z_PENABLE, z_PWRITE;
  logic [7:0] z_rsp_rdata, z_PADDR, z_PWDATA;
  int total = 0, bad = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(.TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master #(.TIMEOUT(0)) dut_nt (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(z_cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .rsp_timeout(z_rsp_timeout), .PSEL(z_PSEL), .PENABLE(z_PENABLE),
    .PWRITE(z_PWRITE), .PADDR(z_PADDR), .PWDATA(z_PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    string nm;
    logic w;
    logic [7:0] a, wd, rd;
    int waits;
    logic serr;
    logic [7:0] erd;
    logic eerr, eto;
    int eacc;
  } vec_t;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // waits < 0 means the completer never raises PREADY
  task automatic xfer(input string nm, input logic w, input logic [7:0] a, input logic [7:0] wd,
                      input logic [7:0] rd, input int waits, input logic serr, input logic [7:0] erd,
                      input logic eerr, input logic eto, input int eacc);
    int acc;
    chk({nm, " cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    PRDATA = rd; PSLVERR = serr; PREADY = 1'b0;
    step();
    cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~wd;
    chk({nm, " setup"}, {PSEL, PENABLE, PWRITE}, {2'b10, w});
    chk({nm, " paddr"}, PADDR, a);
    chk({nm, " pwdata"}, PWDATA, wd);
    step();
    acc = 0;
    while (PENABLE && acc < 200) begin
      chk({nm, " access"}, {PSEL, PADDR, PWDATA}, {1'b1, a, wd});
      PREADY = (waits >= 0) && (acc == waits);
      acc++;
      step();
    end
    PREADY = 1'b0;
    chk({nm, " access_cycles"}, acc, eacc);
    chk({nm, " rsp"}, {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0010);
    chk({nm, " rdata"}, rsp_rdata, erd);
    chk({nm, " err_to"}, {rsp_err, rsp_timeout}, {eerr, eto});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({nm, " release"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    vec_t v[5];
    int stay;
    v[0] = '{"wr5a",  1'b1, 8'h00, 8'h5A, 8'h77,  0, 1'b0, 8'h00, 1'b0, 1'b0,  1};
    v[1] = '{"rdc3",  1'b0, 8'h04, 8'h00, 8'hC3,  3, 1'b0, 8'hC3, 1'b0, 1'b0,  4};
    v[2] = '{"wrerr", 1'b1, 8'h08, 8'h11, 8'hFF,  1, 1'b1, 8'h00, 1'b1, 1'b0,  2};
    v[3] = '{"rderr", 1'b0, 8'h0C, 8'h00, 8'h3C,  0, 1'b1, 8'h3C, 1'b1, 1'b0,  1};
    v[4] = '{"rdto",  1'b0, 8'h10, 8'h00, 8'hAA, -1, 1'b0, 8'h00, 1'b1, 1'b1, 16};

    repeat (3) step();
    chk("reset ctl", {cmd_ready, PSEL, PENABLE, rsp_valid, rsp_err, rsp_timeout, PWRITE}, 0);
    chk("reset data", {rsp_rdata, PADDR, PWDATA}, 0);
    PRESETn = 1'b1;
    step();
    chk("reset release rdy", cmd_ready, 1);

    // response backpressure: a pending command must wait for the handshake
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; PRDATA = 8'h5E; PREADY = 1'b1;
    step();
    cmd_addr = 8'h30;
    step();
    step();
    PREADY = 1'b0;
    chk("bp latency", {PSEL, rsp_valid}, 2'b01);
    for (int i = 0; i < 5; i++) begin
      chk("bp hold", {rsp_valid, cmd_ready, PSEL}, 3'b100);
      chk("bp rdata", rsp_rdata, 8'h5E);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp ready after", {rsp_valid, cmd_ready}, 2'b01);
    step();
    cmd_valid = 1'b0;
    chk("bp next setup", {PSEL, PENABLE}, 2'b10);
    chk("bp next addr", PADDR, 8'h30);
    PREADY = 1'b1;
    step();
    step();
    PREADY = 1'b0;
    chk("bp next rsp", {rsp_valid, rsp_rdata}, {1'b1, 8'h5E});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    for (int i = 0; i < 5; i++)
      xfer(v[i].nm, v[i].w, v[i].a, v[i].wd, v[i].rd, v[i].waits, v[i].serr,
           v[i].erd, v[i].eerr, v[i].eto, v[i].eacc);

    // the TIMEOUT=0 instance has been stuck in ACCESS since the timeout vector began
    stay = 0;
    for (int i = 0; i < 100; i++) begin
      if (z_PSEL && z_PENABLE && !z_rsp_valid) stay++;
      step();
    end
    chk("no timeout stays", stay, 100);
    PRESETn = 1'b0;
    step();
    chk("no timeout reset", {z_PSEL, z_PENABLE, z_rsp_valid}, 0);
    PRESETn = 1'b1;
    step();

    // reset abort during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; PREADY = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("abort in access", {PSEL, PENABLE}, 2'b11);
    PRESETn = 1'b0;
    step();
    chk("abort dropped", {PSEL, PENABLE, rsp_valid, cmd_ready}, 0);
    PRESETn = 1'b1;
    step();
    chk("abort no rsp", {rsp_valid, cmd_ready}, 2'b01);
    xfer("post", 1'b0, 8'h44, 8'h00, 8'h99, 2, 1'b0, 8'h99, 1'b0, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
